// File: rtl/dma_copy_master.sv
// dma_copy_master: copies word_count 32-bit words from src_addr to dst_addr over a
// native valid/ready memory bus, one read then one write per word, with a one-cycle
// idle gap between consecutive bus transactions.
//
// Ports:
//   sys_clk, sys_reset        clock and synchronous active-high reset
//   start                     one-cycle request, sampled only in IDLE
//   src_addr, dst_addr        byte addresses of the first source/destination words
//   word_count                number of words to copy
//   busy                      high while a copy is on the bus (READ, GAP, WRITE)
//   done, error               one-cycle completion pulse; error marks a misaligned request
//   mem_valid, mem_instr      bus request (registered); mem_instr is tied low
//   mem_ready                 responder acknowledge
//   mem_addr, mem_wdata       word-aligned address and write data
//   mem_wstrb                 4'h0 for reads, 4'hF for writes
//   mem_rdata                 read data, valid in the mem_ready cycle
module dma_copy_master #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               sys_clk,
    input  logic               sys_reset,
    input  logic               start,
    input  logic [31:0]        src_addr,
    input  logic [31:0]        dst_addr,
    input  logic [COUNT_W-1:0] word_count,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               mem_valid,
    output logic               mem_instr,
    input  logic               mem_ready,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_wstrb,
    input  logic [31:0]        mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StGap,
        StWrite,
        StFin
    } state_e;

    localparam logic [COUNT_W-1:0] CountOne = COUNT_W'(1);

    state_e             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [31:0]        data_q, data_d;
    logic               phase_q, phase_d;  // 1: the next bus access after GAP is a write
    logic               err_q, err_d;

    // Bus and status outputs are registered from the next state so that they are
    // glitch-free and line up exactly with the state they describe.
    logic               valid_q, valid_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        phase_d = phase_q;
        err_d   = err_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    // Misalignment wins over a zero count.
                    if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else if (word_count == '0) begin
                        err_d   = 1'b0;
                        state_d = StFin;
                    end else begin
                        err_d   = 1'b0;
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        rem_d   = word_count;
                        phase_d = 1'b0;
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (mem_ready) begin
                    data_d  = mem_rdata;
                    phase_d = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = phase_q ? StWrite : StRead;
            end
            StWrite: begin
                if (mem_ready) begin
                    // 32-bit adds wrap naturally modulo 2^32.
                    src_d = src_q + 32'd4;
                    dst_d = dst_q + 32'd4;
                    rem_d = rem_q - CountOne;
                    if (rem_q == CountOne) begin
                        state_d = StFin;
                    end else begin
                        phase_d = 1'b0;
                        state_d = StGap;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        valid_d = (state_d == StRead) || (state_d == StWrite);
        busy_d  = (state_d == StRead) || (state_d == StGap) || (state_d == StWrite);
        done_d  = (state_d == StFin);
        error_d = (state_d == StFin) && err_d;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = 4'h0;
        if (state_d == StRead) begin
            addr_d = src_d;
        end else if (state_d == StWrite) begin
            addr_d  = dst_d;
            wdata_d = data_d;
            wstrb_d = 4'hF;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            phase_q <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign mem_valid = valid_q;
    assign mem_instr = 1'b0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_dma_copy_master.sv
// tb_dma_copy_master: table-driven bench for dma_copy_master with a scoreboard of
// expected bus transactions, a ROM-style responder with configurable wait states,
// and hand-written sequences for reset mid-transfer and ignored restarts.
module tb_dma_copy_master;

    logic        sys_clk;
    logic        sys_reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        error;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    dma_copy_master #(.COUNT_W(16)) dut (
        .sys_clk    (sys_clk),
        .sys_reset  (sys_reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] cnt;
        int          waits;
        bit          glitch;   // pulse a second start mid-transfer
        bit          exp_err;
        int          exp_lat;  // clock edges from the start-sampling edge to done
    } vec_t;

    txn_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   waits  = 0;
    int   hs_cnt = 0;
    int   valid_cnt = 0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_9617;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Responder and bus monitor: decides mem_ready on the falling edge, so the
    // handshake it grants completes at the following rising edge.
    initial begin
        int          wait_cnt;
        bit          in_txn;
        bit          hs_prev;
        logic [67:0] hold;
        txn_t        exp;
        wait_cnt  = 0;
        in_txn    = 0;
        hs_prev   = 0;
        hold      = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge sys_clk);
            if (hs_prev) chk("valid_after_handshake", {63'd0, mem_valid}, 64'd0);
            hs_prev = 0;
            if (mem_valid) begin
                valid_cnt++;
                if (!in_txn) begin
                    hold   = {mem_addr, mem_wstrb, mem_wdata};
                    in_txn = 1;
                end else begin
                    chk("stable_addr", {32'd0, mem_addr}, {32'd0, hold[67:36]});
                    chk("stable_wstrb", {60'd0, mem_wstrb}, {60'd0, hold[35:32]});
                    chk("stable_wdata", {32'd0, mem_wdata}, {32'd0, hold[31:0]});
                end
                if (wait_cnt < waits) begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = pat(mem_addr);
                    wait_cnt  = 0;
                    in_txn    = 0;
                    hs_prev   = 1;
                    hs_cnt++;
                    if (sb.size() == 0) begin
                        chk("unexpected_txn_sb_size", 64'(sb.size()), 64'd1);
                    end else begin
                        exp = sb.pop_front();
                        chk("txn_addr", {32'd0, mem_addr}, {32'd0, exp.addr});
                        chk("txn_wstrb", {60'd0, mem_wstrb}, {60'd0, exp.wstrb});
                        if (exp.wstrb == 4'hF)
                            chk("txn_wdata", {32'd0, mem_wdata}, {32'd0, exp.data});
                    end
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
                in_txn    = 0;
            end
        end
    end

    task automatic push_expected(input logic [31:0] src, input logic [31:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] s;
            logic [31:0] d;
            s = src + 32'(4 * i);
            d = dst + 32'(4 * i);
            sb.push_back('{addr: s, wstrb: 4'h0, data: 32'd0});
            sb.push_back('{addr: d, wstrb: 4'hF, data: pat(s)});
        end
    endtask

    task automatic run(input vec_t v);
        int lat;
        bit seen;
        int hs0;
        int val0;
        bit exp_bus;
        exp_bus = !v.exp_err && (v.cnt != 16'd0);
        waits   = v.waits;
        if (exp_bus) push_expected(v.src, v.dst, int'(v.cnt));
        hs0  = hs_cnt;
        val0 = valid_cnt;
        @(negedge sys_clk);
        start      = 1'b1;
        src_addr   = v.src;
        dst_addr   = v.dst;
        word_count = v.cnt;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 400) begin
            @(negedge sys_clk);
            lat++;
            start = v.glitch && (lat == 3);
            if (start) begin
                src_addr   = 32'h0000_0040;
                dst_addr   = 32'h0000_0080;
                word_count = 16'd7;
            end
            if (lat == 1) chk("busy_first_cycle", {63'd0, busy}, {63'd0, exp_bus});
            if (done) seen = 1;
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        if (seen) begin
            chk("done_latency", 64'(lat), 64'(v.exp_lat));
            chk("error_with_done", {63'd0, error}, {63'd0, v.exp_err});
            chk("busy_at_done", {63'd0, busy}, 64'd0);
            chk("handshakes", 64'(hs_cnt - hs0), 64'(exp_bus ? 2 * int'(v.cnt) : 0));
            chk("valid_cycles", 64'(valid_cnt - val0),
                64'(exp_bus ? 2 * int'(v.cnt) * (v.waits + 1) : 0));
            chk("sb_drained", 64'(sb.size()), 64'd0);
            @(negedge sys_clk);
            chk("done_one_cycle", {62'd0, done, error}, 64'd0);
        end
        sb.delete();
    endtask

    vec_t vecs[8];

    initial begin
        bit done_seen;
        vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3, 0, 1'b0, 1'b0, 12};
        vecs[1] = '{32'h0000_1000, 32'h0000_2000, 16'd3, 3, 1'b0, 1'b0, 30};
        vecs[2] = '{32'h0000_0300, 32'h0000_0400, 16'd0, 0, 1'b0, 1'b0, 1};
        vecs[3] = '{32'h0000_0102, 32'h0000_0400, 16'd2, 0, 1'b0, 1'b1, 1};
        vecs[4] = '{32'h0000_0100, 32'h0000_0403, 16'd0, 0, 1'b0, 1'b1, 1};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0500, 16'd2, 1, 1'b1, 1'b0, 12};
        vecs[6] = '{32'h0000_0600, 32'h0000_0700, 16'd1, 2, 1'b0, 1'b0, 8};
        vecs[7] = '{32'h0000_0800, 32'h0000_0900, 16'd5, 0, 1'b0, 1'b0, 20};

        sys_reset  = 1'b1;
        start      = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        word_count = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_busy_done_error", {61'd0, busy, done, error}, 64'd0);
        chk("rst_mem_instr", {63'd0, mem_instr}, 64'd0);
        chk("rst_mem_wstrb", {60'd0, mem_wstrb}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        sys_reset = 1'b0;
        @(negedge sys_clk);

        for (int i = 0; i < 8; i++) run(vecs[i]);

        // Reset during the wait states of the second word's write: the first word's
        // read/write and the second read complete, then everything stops silently.
        waits = 2;
        push_expected(32'h0000_0A00, 32'h0000_0B00, 1);
        sb.push_back('{addr: 32'h0000_0A04, wstrb: 4'h0, data: 32'd0});
        @(negedge sys_clk);
        start      = 1'b1;
        src_addr   = 32'h0000_0A00;
        dst_addr   = 32'h0000_0B00;
        word_count = 16'd4;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (12) @(negedge sys_clk);
        chk("mid_write_valid", {63'd0, mem_valid}, 64'd1);
        chk("mid_write_wstrb", {60'd0, mem_wstrb}, 64'hF);
        chk("mid_write_addr", {32'd0, mem_addr}, 64'h0B04);
        sys_reset = 1'b1;
        @(negedge sys_clk);
        chk("reset_drops_valid", {63'd0, mem_valid}, 64'd0);
        chk("reset_drops_busy", {63'd0, busy}, 64'd0);
        chk("reset_mem_instr", {63'd0, mem_instr}, 64'd0);
        sys_reset = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (done) done_seen = 1;
        end
        chk("no_done_after_reset", {63'd0, done_seen}, 64'd0);
        chk("reset_sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();

        run(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
